// File: rtl/prbs_pkg.sv
// prbs_pkg: shared FSM state encoding and default sizes for the PRBS pattern checker
package prbs_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CHECK, ST_DONE} state_t;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_PATTERN_LEN = 4;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_TIMEOUT_CYC = 64;
endpackage

// File: rtl/prbs_chk_ref_store.sv
// prbs_chk_ref_store: PATTERN_LEN x DATA_W reference register file
//   clk, rst_n : clock, async active-low reset (clears every entry)
//   wr         : write strobe, stores data at idx
//   idx        : shared write / read index
//   data       : write data
//   rd_data    : combinational read of entry idx
module prbs_chk_ref_store #(
  parameter int DATA_W      = 8,
  parameter int PATTERN_LEN = 4,
  parameter int IDX_W       = $clog2(PATTERN_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [PATTERN_LEN];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < PATTERN_LEN; i++) mem[i] <= '0;
    else if (wr) mem[idx] <= data;
  assign rd_data = mem[idx];
endmodule

// File: rtl/prbs_pattern_checker.sv
// prbs_pattern_checker: stores a reference pattern, then checks n repetitions of it on the PRBS output stream
//   clk, rst_n          : clock, async active-low reset
//   start, n_pattern    : begin a run (abort any run in progress), repetitions to check
//   pat_wr, pat_in      : reference byte write during LOAD
//   data_valid, data_in : generator byte to compare during CHECK
//   busy, done, pass    : run status (pass valid while done)
//   err_cnt, rep_cnt    : saturating mismatch count, completed repetitions
//   timeout             : CHECK starved of data (only with PRBS_CHK_TIMEOUT_EN defined, else 0)
module prbs_pattern_checker
  import prbs_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int PATTERN_LEN = DEF_PATTERN_LEN,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_pattern,
  input  logic              pat_wr,
  input  logic [DATA_W-1:0] pat_in,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  rep_cnt,
  output logic              timeout
);
  localparam int IDX_W = $clog2(PATTERN_LEN);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(PATTERN_LEN - 1);
  state_t state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] n_lat;
  logic [DATA_W-1:0] ref_byte;
  logic chk, wrap, last_rep, idle_hit, timeout_r;
  assign chk      = state == ST_CHECK && data_valid;
  assign wrap     = idx == LAST;
  assign last_rep = rep_cnt + CNT_W'(1) == n_lat;
  prbs_chk_ref_store #(.DATA_W(DATA_W), .PATTERN_LEN(PATTERN_LEN), .IDX_W(IDX_W)) u_ref (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (state == ST_LOAD && pat_wr && !start),
    .idx     (idx),
    .data    (pat_in),
    .rd_data (ref_byte)
  );
`ifdef PRBS_CHK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt;
  assign idle_hit = state == ST_CHECK && !data_valid && idle_cnt == TO_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idle_cnt <= '0;
    else idle_cnt <= (state == ST_CHECK && !data_valid && !start) ? idle_cnt + TO_W'(1) : '0;
`else
  // timeout disabled: never fires
  assign idle_hit = TIMEOUT_CYC < 0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;
  // start wins over every other event; a zero-length run completes immediately with pass
  always_comb
    state_nx = start ? (n_pattern == '0 ? ST_DONE : ST_LOAD) :
               (state == ST_LOAD && pat_wr && wrap) ? ST_CHECK :
               ((chk && wrap && last_rep) || idle_hit) ? ST_DONE : state;
  always_comb begin
    busy    = state == ST_LOAD || state == ST_CHECK;
    done    = state == ST_DONE;
    pass    = done && err_cnt == '0 && !timeout_r;
    timeout = timeout_r;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx       <= '0;
      n_lat     <= '0;
      err_cnt   <= '0;
      rep_cnt   <= '0;
      timeout_r <= 1'b0;
    end else if (start) begin
      idx       <= '0;
      n_lat     <= n_pattern;
      err_cnt   <= '0;
      rep_cnt   <= '0;
      timeout_r <= 1'b0;
    end else begin
      if ((state == ST_LOAD && pat_wr) || chk) idx <= wrap ? '0 : idx + IDX_W'(1);
      if (chk && data_in != ref_byte && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      if (chk && wrap) rep_cnt <= rep_cnt + CNT_W'(1);
      if (idle_hit) timeout_r <= 1'b1;
    end
endmodule

// File: tb/tb_prbs_pattern_checker.sv
// tb_prbs_pattern_checker: table-driven directed bench for prbs_pattern_checker
module tb_prbs_pattern_checker;
  typedef struct {
    logic       st;
    logic [7:0] n;
    logic       wr;
    logic [7:0] pin;
    logic       dv;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err;
    logic [7:0] rep;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pat_wr = 1'b0, data_valid = 1'b0;
  logic [7:0] n_pattern = '0, pat_in = '0, data_in = '0;
  logic busy, done, pass, timeout;
  logic [7:0] err_cnt, rep_cnt;
  int checks = 0, failures = 0;
  vec_t tbl[$];
  prbs_pattern_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .n_pattern  (n_pattern),
    .pat_wr     (pat_wr),
    .pat_in     (pat_in),
    .data_valid (data_valid),
    .data_in    (data_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .rep_cnt    (rep_cnt),
    .timeout    (timeout)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_out(input string tag, input int b, input int d, input int p, input int e, input int r);
    check({tag, ".busy"}, int'(busy), b);
    check({tag, ".done"}, int'(done), d);
    check({tag, ".pass"}, int'(pass), p);
    check({tag, ".err_cnt"}, int'(err_cnt), e);
    check({tag, ".rep_cnt"}, int'(rep_cnt), r);
  endtask
  task automatic cyc(input int st, input int n, input int wr, input int pin, input int dv, input int din);
    start = 1'(st);
    n_pattern = 8'(n);
    pat_wr = 1'(wr);
    pat_in = 8'(pin);
    data_valid = 1'(dv);
    data_in = 8'(din);
    @(posedge clk);
    #1;
  endtask
  task automatic add(input int st, input int n, input int wr, input int pin, input int dv, input int din,
                     input int b, input int d, input int p, input int e, input int r);
    tbl.push_back('{1'(st), 8'(n), 1'(wr), 8'(pin), 1'(dv), 8'(din), 1'(b), 1'(d), 1'(p), 8'(e), 8'(r)});
  endtask
  task automatic load4(input int a, input int b, input int c, input int d);
    cyc(0, 0, 1, a, 0, 0);
    cyc(0, 0, 1, b, 0, 0);
    cyc(0, 0, 1, c, 0, 0);
    cyc(0, 0, 1, d, 0, 0);
  endtask
  initial begin
    // n=1 single clean repetition
    add(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'h10, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'hAB, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'hCD, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'hEF, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 'h10, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 'hAB, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 'hCD, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 'hEF, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    // n=2, one bad byte in the second repetition; stray data in LOAD and pat_wr in CHECK/DONE ignored
    add(1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'h10, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 'h55, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'hAB, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'hCD, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'hEF, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 'h10, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 'hAB, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 'hCD, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 'hEF, 1, 0, 0, 0, 1);
    add(0, 0, 1, 'h00, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 'h10, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 'hAB, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 'h00, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 'hEF, 0, 1, 0, 1, 2);
    add(0, 0, 0, 0, 1, 'h11, 0, 1, 0, 1, 2);
    add(0, 0, 1, 'h22, 0, 0, 0, 1, 0, 1, 2);
    // n=0 completes at once with pass, never busy
    add(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    // n=3 aborted by a restart mid-CHECK, then a clean run of 01..04 x3
    add(1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'h11, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'h22, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'h33, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'h44, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 'h11, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 'h22, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 'h99, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 'h44, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 'h11, 1, 0, 0, 1, 1);
    add(1, 3, 0, 0, 1, 'h22, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'h01, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'h02, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'h03, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 'h04, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++)
      add(0, 0, 0, 0, 1, ((k - 1) % 4) + 1, int'(k < 12), int'(k == 12), int'(k == 12), 0, k / 4);
    // asynchronous reset in the middle of CHECK
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk_out("reset_idle", 0, 0, 0, 0, 0);
    check("reset_idle.timeout", int'(timeout), 0);
    rst_n = 1'b1;
    cyc(1, 1, 0, 0, 0, 0);
    load4('h10, 'hAB, 'hCD, 'hEF);
    cyc(0, 0, 0, 0, 1, 'h10);
    cyc(0, 0, 0, 0, 1, 'h00);
    chk_out("pre_reset", 1, 0, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("mid_check_reset", 0, 0, 0, 0, 0);
    check("mid_check_reset.timeout", int'(timeout), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    foreach (tbl[i]) begin
      cyc(tbl[i].st, tbl[i].n, tbl[i].wr, tbl[i].pin, tbl[i].dv, tbl[i].din);
      chk_out($sformatf("vec%0d", i), tbl[i].busy, tbl[i].done, tbl[i].pass, tbl[i].err, tbl[i].rep);
    end
    // n=100, every byte wrong: err_cnt saturates while rep_cnt still reaches 100
    cyc(1, 100, 0, 0, 0, 0);
    load4('h00, 'h01, 'h02, 'h03);
    for (int j = 1; j <= 400; j++) begin
      cyc(0, 0, 0, 0, 1, 'hFF);
      if (j == 254) check("sat.err_254", int'(err_cnt), 'hFE);
      if (j == 255) check("sat.err_255", int'(err_cnt), 'hFF);
      if (j == 256) check("sat.err_256", int'(err_cnt), 'hFF);
      if (j == 399) check("sat.done_399", int'(done), 0);
    end
    chk_out("sat_end", 0, 1, 0, 'hFF, 100);
    // stall after two bytes
    cyc(1, 100, 0, 0, 0, 0);
    load4('h00, 'h01, 'h02, 'h03);
    cyc(0, 0, 0, 0, 1, 'h00);
    cyc(0, 0, 0, 0, 1, 'h01);
`ifdef PRBS_CHK_TIMEOUT_EN
    for (int j = 0; j < 63; j++) cyc(0, 0, 0, 0, 0, 0);
    check("stall63.done", int'(done), 0);
    check("stall63.timeout", int'(timeout), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk_out("stall64", 0, 1, 0, 0, 0);
    check("stall64.timeout", int'(timeout), 1);
`else
    for (int j = 0; j < 70; j++) cyc(0, 0, 0, 0, 0, 0);
    chk_out("stall70", 1, 0, 0, 0, 0);
    check("stall70.timeout", int'(timeout), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
